// File: rtl/regfile_read_stage.sv
// Purpose: architectural register file with two bypassed read ports feeding the ID/EX register.
// Latency: operands are read combinationally and registered into ID/EX at the next rising edge.
// Backpressure: id_stall holds decode on a load-use hazard; one bubble enters execute; flush squashes.
//
// Ports:
//   clk, rst                               clock (rising edge), asynchronous active-high reset
//   wb_regwrite, wb_rd, wb_data            writeback write port
//   id_valid, id_rs1, id_rs2, id_rd,
//   id_regwrite, id_memread                decode slot instruction fields
//   flush                                  squash the instruction entering execute
//   id_stall                               combinational hold request to decode/fetch
//   ex_valid, ex_rs1_data, ex_rs2_data,
//   ex_rd, ex_regwrite, ex_memread         ID/EX pipeline register outputs
//   stall_count                            saturating count of stall cycles
module regfile_read_stage #(
    parameter int d_size = 32,
    parameter int r_size = 5,
    parameter int n_regs = 32,
    parameter int c_size = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_regwrite,
    input  logic [r_size-1:0] wb_rd,
    input  logic [d_size-1:0] wb_data,
    input  logic              id_valid,
    input  logic [r_size-1:0] id_rs1,
    input  logic [r_size-1:0] id_rs2,
    input  logic [r_size-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [d_size-1:0] ex_rs1_data,
    output logic [d_size-1:0] ex_rs2_data,
    output logic [r_size-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [c_size-1:0] stall_count
);

    // Architectural register file; entry 0 is never written so it stays zero.
    logic [d_size-1:0] regs_q [n_regs];

    // ID/EX pipeline register
    logic              ex_valid_q,    ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;
    logic [r_size-1:0] ex_rd_q,       ex_rd_d;
    logic [d_size-1:0] ex_rs1_q,      ex_rs1_d;
    logic [d_size-1:0] ex_rs2_q,      ex_rs2_d;

    logic [c_size-1:0] stall_cnt_q,   stall_cnt_d;

    logic              wb_wr_en;
    logic [d_size-1:0] rs1_val;
    logic [d_size-1:0] rs2_val;
    logic              hazard;

    assign wb_wr_en = wb_regwrite && (wb_rd != '0);

    // Register file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < n_regs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wr_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Operand read with same-cycle writeback bypass; x0 always reads zero,
    // even if writeback targets it in this cycle.
    always_comb begin
        rs1_val = regs_q[id_rs1];
        if (id_rs1 == '0) begin
            rs1_val = '0;
        end else if (wb_regwrite && (wb_rd == id_rs1)) begin
            rs1_val = wb_data;
        end

        rs2_val = regs_q[id_rs2];
        if (id_rs2 == '0) begin
            rs2_val = '0;
        end else if (wb_regwrite && (wb_rd == id_rs2)) begin
            rs2_val = wb_data;
        end
    end

    // Load-use hazard: both sources compared whether or not the instruction
    // actually uses them, so a false stall is possible but a missed one is not.
    assign hazard = id_valid && ex_valid_q && ex_memread_q && ex_regwrite_q &&
                    (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    assign id_stall = hazard;

    // ID/EX next state: flush beats stall, both insert a bubble and hold data fields.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        if (flush || hazard) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
        end else begin
            ex_valid_d    = id_valid;
            ex_regwrite_d = id_regwrite && id_valid;
            ex_memread_d  = id_memread && id_valid;
            ex_rd_d       = id_rd;
            ex_rs1_d      = rs1_val;
            ex_rs2_d      = rs2_val;
        end
    end

    // Stall counter only counts stalls that actually took effect (not flushed),
    // and sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(c_size-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
module tb_regfile_read_stage;

    logic        clk;
    logic        rst;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [15:0] stall_count;

    // Narrow-counter copy sharing all inputs, used to see saturation.
    logic        s_id_stall;
    logic        s_ex_valid;
    logic [31:0] s_ex_rs1_data;
    logic [31:0] s_ex_rs2_data;
    logic [4:0]  s_ex_rd;
    logic        s_ex_regwrite;
    logic        s_ex_memread;
    logic [3:0]  s_stall_count;

    regfile_read_stage dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .stall_count(stall_count)
    );

    regfile_read_stage #(.c_size(4)) dut_sat (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .id_stall(s_id_stall), .ex_valid(s_ex_valid),
        .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_rd(s_ex_rd),
        .ex_regwrite(s_ex_regwrite), .ex_memread(s_ex_memread),
        .stall_count(s_stall_count)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   exp_stalls = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = a;
        id_rs2      = b;
        id_rd       = d;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic set_wb(input logic [4:0] d, input logic [31:0] data);
        wb_regwrite = 1'b1;
        wb_rd       = d;
        wb_data     = data;
    endtask

    // Called at a negedge with inputs already driven: checks the combinational
    // stall, queues the expected ID/EX contents, clocks once and compares.
    task automatic cyc(input logic es, input logic ev, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [4:0] erd,
                       input logic erw, input logic emr);
        exp_t e;
        int   sat;
        #1;
        check_val("id_stall", 32'(id_stall), 32'(es));
        if (es && !flush) exp_stalls++;
        e.v = ev; e.r1 = e1; e.r2 = e2; e.rd = erd; e.rw = erw; e.mr = emr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("ex_valid",    32'(ex_valid),    32'(e.v));
        check_val("ex_rs1_data", ex_rs1_data,      e.r1);
        check_val("ex_rs2_data", ex_rs2_data,      e.r2);
        check_val("ex_rd",       32'(ex_rd),       32'(e.rd));
        check_val("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
        check_val("ex_memread",  32'(ex_memread),  32'(e.mr));
        check_val("stall_count", 32'(stall_count), 32'(exp_stalls));
        sat = (exp_stalls > 15) ? 15 : exp_stalls;
        check_val("stall_count_sat", 32'(s_stall_count), 32'(sat));
        @(negedge clk);
        wb_regwrite = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        flush       = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ex_valid",    32'(ex_valid),    32'd0);
        check_val("rst_ex_rs1",      ex_rs1_data,      32'd0);
        check_val("rst_ex_rd",       32'(ex_rd),       32'd0);
        check_val("rst_stall_count", 32'(stall_count), 32'd0);
        rst = 1'b0;

        // Read after reset: r5 never written
        set_id(1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0);

        // Write r3, then attempt to write r0
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        set_wb(5'd3, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set_wb(5'd0, 32'h1234);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set_id(1'b1, 5'd3, 5'd0, 5'd2, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 5'd2, 1'b1, 1'b0);

        // Same-cycle bypass on r7, then plain read of the new value
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        set_wb(5'd7, 32'h11);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0);
        set_wb(5'd7, 32'h22);
        cyc(1'b0, 1'b1, 32'hDEADBEEF, 32'h22, 5'd8, 1'b1, 1'b0);
        set_id(1'b1, 5'd7, 5'd7, 5'd8, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h22, 32'h22, 5'd8, 1'b0, 1'b0);

        // Load-use on rs1: one bubble, then issue with load data arriving by bypass
        set_id(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 5'd4, 1'b1, 1'b1);
        set_id(1'b1, 5'd4, 5'd7, 5'd5, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd4, 1'b0, 1'b0);
        set_wb(5'd4, 32'h44);
        cyc(1'b0, 1'b1, 32'h44, 32'h22, 5'd5, 1'b1, 1'b0);

        // Load to x0 never causes a stall
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0);

        // Load-use on rs2
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
        set_id(1'b1, 5'd1, 5'd9, 5'd10, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 5'd9, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd10, 1'b0, 1'b0);

        // Flush together with a load-use stall: flush wins, no count
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1);
        set_id(1'b1, 5'd4, 5'd0, 5'd5, 1'b0, 1'b0);
        flush = 1'b1;
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h44, 32'h0, 5'd5, 1'b0, 1'b0);

        // Invalid decode slot does not stall even on an index match
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1);
        set_id(1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'h44, 32'h0, 5'd0, 1'b0, 1'b0);

        // 20 load-use stalls: wide counter keeps counting, narrow one sticks at 15
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
            cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1);
            set_id(1'b1, 5'd4, 5'd0, 5'd5, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 32'h44, 32'h0, 5'd5, 1'b0, 1'b0);
        end
        check_val("sat_final", 32'(s_stall_count), 32'd15);

        // Asynchronous reset pulse between edges
        set_id(1'b0, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_val("arst_ex_valid",    32'(ex_valid),      32'd0);
        check_val("arst_ex_rs1",      ex_rs1_data,        32'd0);
        check_val("arst_ex_rd",       32'(ex_rd),         32'd0);
        check_val("arst_stall_count", 32'(stall_count),   32'd0);
        check_val("arst_sat_count",   32'(s_stall_count), 32'd0);
        rst = 1'b0;
        exp_stalls = 0;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        // Array contents were cleared by the reset
        set_id(1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
